// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock key-entry slice.
//   state_t : entry controller states
//   digit_t : one BCD digit
//   time_ok : range check of a full HH:MM buffer
package aclk_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    COMMIT_A,
    COMMIT_C
  } state_t;

  localparam digit_t KEY_MAX_DIGIT  = 4'd9;
  localparam digit_t HR_MS_MAX      = 4'd2;
  localparam digit_t HR_LS_MAX_AT_2 = 4'd3;
  localparam digit_t MIN_MS_MAX     = 4'd5;

  function automatic logic time_ok(input digit_t ms_hr, input digit_t ls_hr,
                                   input digit_t ms_min, input logic [2:0] count);
    time_ok = (count == 3'd4) &&
              (ms_hr <= HR_MS_MAX) &&
              !((ms_hr == HR_MS_MAX) && (ls_hr > HR_LS_MAX_AT_2)) &&
              (ms_min <= MIN_MS_MAX);
  endfunction

endpackage

// File: rtl/aclk_digit_shreg.sv
// Four-digit HH:MM shift buffer with entered-digit count.
// Ports:
//   clk, reset     : clock, async active-low reset
//   clr            : zero digits and count
//   cnt_clr        : zero count only (digits held)
//   shift, din     : shift din in at ls_min; applied after clr/cnt_clr
//   ms_hr..ls_min  : buffered digits (registered)
//   count          : digits entered, saturates at 4
module aclk_digit_shreg
  import aclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       cnt_clr,
  input  logic       shift,
  input  digit_t     din,
  output digit_t     ms_hr,
  output digit_t     ls_hr,
  output digit_t     ms_min,
  output digit_t     ls_min,
  output logic [2:0] count
);

  logic [15:0] buf_q, buf_d;
  logic [2:0]  count_q, count_d;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (clr) begin
      buf_d   = '0;
      count_d = '0;
    end
    if (cnt_clr) count_d = '0;
    if (shift) begin
      buf_d = {buf_d[11:0], din};
      if (count_d != 3'd4) count_d = count_d + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign ms_hr  = buf_q[15:12];
  assign ls_hr  = buf_q[11:8];
  assign ms_min = buf_q[7:4];
  assign ls_min = buf_q[3:0];
  assign count  = count_q;

endmodule

// File: rtl/aclk_key_entry.sv
// Keypad digit-entry and commit controller for the alarm clock.
// Optional feature: define ACLK_ENTRY_TIMEOUT_EN to abandon an entry after
// TIMEOUT_S one_second ticks without a digit.
// Ports:
//   clk, reset                 : clock, async active-low reset
//   one_second                 : 1 Hz tick (timeout build only)
//   key_valid, key             : keypad strobe and code (0-9 digits)
//   alarm_btn, time_btn        : commit strobes
//   new_ms_hr..new_ls_min      : buffered digits
//   load_new_a, load_new_c     : one-cycle load strobes
//   show_new_time              : high while entering
//   entry_err                  : one-cycle pulse on rejected commit
module aclk_key_entry
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned TMR_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       alarm_btn,
  input  logic       time_btn,
  output logic [3:0] new_ms_hr,
  output logic [3:0] new_ls_hr,
  output logic [3:0] new_ms_min,
  output logic [3:0] new_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       entry_err
);

  state_t     state_q, state_d;
  logic       entry_err_q, entry_err_d;
  logic       clr, cnt_clr, shift;
  logic [2:0] count;
  logic       digit_key;

  assign digit_key = key_valid && (key <= KEY_MAX_DIGIT);

  aclk_digit_shreg u_shreg (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .cnt_clr(cnt_clr),
    .shift  (shift),
    .din    (key),
    .ms_hr  (new_ms_hr),
    .ls_hr  (new_ls_hr),
    .ms_min (new_ms_min),
    .ls_min (new_ls_min),
    .count  (count)
  );

`ifdef ACLK_ENTRY_TIMEOUT_EN
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign expire = one_second && ((tmr_q + TMR_W'(1)) == TMR_W'(TIMEOUT_S));
`else
  logic [TMR_W-1:0] unused_tmr;
  assign unused_tmr = TMR_W'(TIMEOUT_S) ^ {TMR_W{one_second}};
`endif

  always_comb begin
    state_d     = state_q;
    entry_err_d = 1'b0;
    clr         = 1'b0;
    cnt_clr     = 1'b0;
    shift       = 1'b0;
`ifdef ACLK_ENTRY_TIMEOUT_EN
    tmr_d       = tmr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (digit_key) begin
          clr     = 1'b1;
          shift   = 1'b1;
          state_d = ENTRY;
`ifdef ACLK_ENTRY_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end
      end
      ENTRY: begin
        // Buttons outrank keys; a same-cycle key is dropped.
        if (alarm_btn || time_btn) begin
          if (alarm_btn && time_btn) begin
            entry_err_d = 1'b1;
          end else if (time_ok(new_ms_hr, new_ls_hr, new_ms_min, count)) begin
            state_d = alarm_btn ? COMMIT_A : COMMIT_C;
          end else begin
            entry_err_d = 1'b1;
          end
        end else if (digit_key) begin
          shift = 1'b1;
`ifdef ACLK_ENTRY_TIMEOUT_EN
          tmr_d = '0;
        end else if (expire) begin
          clr     = 1'b1;
          state_d = IDLE;
          tmr_d   = '0;
        end else if (one_second) begin
          tmr_d = tmr_q + TMR_W'(1);
`endif
        end
      end
      COMMIT_A, COMMIT_C: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      entry_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_err_q <= entry_err_d;
    end
  end

  assign load_new_a    = (state_q == COMMIT_A);
  assign load_new_c    = (state_q == COMMIT_C);
  assign show_new_time = (state_q == ENTRY);
  assign entry_err     = entry_err_q;

endmodule

// File: tb/tb_aclk_key_entry.sv
module tb_aclk_key_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       alarm_btn = 1'b0;
  logic       time_btn = 1'b0;
  logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
  logic       load_new_a, load_new_c, show_new_time, entry_err;

  int checks = 0;
  int failures = 0;

  aclk_key_entry #(.TIMEOUT_S(3), .TMR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .one_second   (one_second),
    .key_valid    (key_valid),
    .key          (key),
    .alarm_btn    (alarm_btn),
    .time_btn     (time_btn),
    .new_ms_hr    (new_ms_hr),
    .new_ls_hr    (new_ls_hr),
    .new_ms_min   (new_ms_min),
    .new_ls_min   (new_ls_min),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .show_new_time(show_new_time),
    .entry_err    (entry_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags packed as {load_new_a, load_new_c, show_new_time, entry_err}.
  function automatic logic [15:0] flags();
    return {12'd0, load_new_a, load_new_c, show_new_time, entry_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic btn(input logic a, input logic t);
    alarm_btn = a;
    time_btn = t;
    step();
    alarm_btn = 1'b0;
    time_btn = 1'b0;
  endtask

  task automatic tick();
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    step();
  endtask

  initial begin
    // reset state
    step(); step();
    check("reset_digits", digits(), 16'h0000);
    check("reset_flags", flags(), 16'h0);
    @(posedge clk); #1 reset = 1'b1;
    step();
    check("idle_flags", flags(), 16'h0);

    // 12:30 alarm commit
    press(4'd1);
    check("entry_first_digit", digits(), 16'h0001);
    check("entry_show", flags(), 16'h2);
    press(4'd2); press(4'd3); press(4'd0);
    check("buf_1230", digits(), 16'h1230);
    btn(1'b1, 1'b0);
    check("commit_a_flags", flags(), 16'h8);
    check("commit_a_digits", digits(), 16'h1230);
    step();
    check("after_commit_a_flags", flags(), 16'h0);
    check("after_commit_a_digits", digits(), 16'h1230);

    // 24:00 rejected, then 23:59 time commit
    press(4'd2); press(4'd4); press(4'd0); press(4'd0);
    btn(1'b0, 1'b1);
    check("err_2400_flags", flags(), 16'h3);
    check("err_2400_digits", digits(), 16'h2400);
    step();
    check("err_2400_clear", flags(), 16'h2);
    press(4'd2); press(4'd3); press(4'd5); press(4'd9);
    check("buf_2359", digits(), 16'h2359);
    btn(1'b0, 1'b1);
    check("commit_c_flags", flags(), 16'h4);
    check("commit_c_digits", digits(), 16'h2359);
    step();
    check("after_commit_c_flags", flags(), 16'h0);

    // short entry rejected; five digits keep last four
    press(4'd0); press(4'd7); press(4'd1);
    check("buf_0071", digits(), 16'h0071);
    btn(1'b1, 1'b0);
    check("err_short_flags", flags(), 16'h3);
    check("err_short_digits", digits(), 16'h0071);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("buf_2345", digits(), 16'h2345);
    btn(1'b1, 1'b0);
    check("commit_2345_flags", flags(), 16'h8);
    step();

    // non-digit codes ignored
    press(4'd11);
    check("idle_key11", flags(), 16'h0);
    press(4'd0); press(4'd11); press(4'd9); press(4'd11);
    press(4'd0); press(4'd0); press(4'd11);
    check("buf_0900", digits(), 16'h0900);
    btn(1'b1, 1'b1);
    check("both_btn_flags", flags(), 16'h3);
    check("both_btn_digits", digits(), 16'h0900);
    // button with key in same cycle: key dropped
    key_valid = 1'b1; key = 4'd5;
    btn(1'b1, 1'b0);
    key_valid = 1'b0;
    check("btn_key_flags", flags(), 16'h8);
    check("btn_key_digits", digits(), 16'h0900);
    step();

    press(4'd5);
    tick(); tick();
    check("tick2_show", flags(), 16'h2);
`ifdef ACLK_ENTRY_TIMEOUT_EN
    tick();
    check("timeout_flags", flags(), 16'h0);
    check("timeout_digits", digits(), 16'h0000);
    press(4'd5);
    tick(); tick();
    one_second = 1'b1; key_valid = 1'b1; key = 4'd6;
    step();
    one_second = 1'b0; key_valid = 1'b0;
    check("tick_digit_flags", flags(), 16'h2);
    check("tick_digit_digits", digits(), 16'h0056);
    tick();
    check("tick_restart_show", flags(), 16'h2);
`else
    tick(); tick(); tick();
    check("no_timeout_flags", flags(), 16'h2);
    check("no_timeout_digits", digits(), 16'h0005);
`endif

    // reset during COMMIT_A
    press(4'd1); press(4'd2); press(4'd0); press(4'd0);
    btn(1'b1, 1'b0);
    check("pre_reset_load", flags(), 16'h8);
    #2 reset = 1'b0;
    #1;
    check("async_reset_flags", flags(), 16'h0);
    check("async_reset_digits", digits(), 16'h0000);
    @(posedge clk); #1 reset = 1'b1;
    step();
    check("post_reset_flags1", flags(), 16'h0);
    step();
    check("post_reset_flags2", flags(), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
